// File: rtl/adc_axis_pkg.sv
// rtl/adc_axis_pkg.sv - shared state type and elaboration helpers for adc_axis_packer
package adc_axis_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    function automatic int calc_beats(input int num_ch, input int sample_w, input int axis_w);
        return (num_ch * sample_w) / axis_w;
    endfunction

    // Pointer/counter width that never collapses to zero bits
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit frame_fits(input int num_ch, input int sample_w, input int axis_w);
        return ((axis_w % 8) == 0) && (((num_ch * sample_w) % axis_w) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock frame FIFO with registered read data
module sync_fifo
    import adc_axis_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [ptr_w(DEPTH):0]   count
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_axis_packer.sv
// rtl/adc_axis_packer.sv - ADC frame capture into AXIS beats; ADC_AXIS_PACKER_TEST_PATTERN_EN adds test_mode
module adc_axis_packer
    import adc_axis_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 16,
    parameter int AXIS_W     = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         adc_clk,
    input  logic                         adc_rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    input  logic                         ch_valid,
    input  logic [31:0]                  sample_len,
    input  logic                         sample_start,
`ifdef ADC_AXIS_PACKER_TEST_PATTERN_EN
    input  logic                         test_mode,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [AXIS_W-1:0]            m_axis_tdata,
    output logic [AXIS_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    localparam int FW    = NUM_CH * SAMPLE_W;
    localparam int BEATS = calc_beats(NUM_CH, SAMPLE_W, AXIS_W);
    localparam int BW    = ptr_w(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!frame_fits(NUM_CH, SAMPLE_W, AXIS_W)) begin : g_bad_width
        $error("adc_axis_packer: frame width must be a multiple of AXIS_W, AXIS_W a multiple of 8");
    end

    state_t                    state;
    logic                      start_q;
    logic [31:0]               len_q;
    logic [31:0]               frame_cnt;
    logic [31:0]               out_frame_cnt;
    logic [BW-1:0]             beat_cnt;
    logic [FW-1:0]             wr_frame;
    logic [FW-1:0]             rd_frame;
    logic                      wr_req;
    logic                      wr_ok;
    logic                      wr_en;
    logic                      rd_en;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ptr_w(FIFO_DEPTH):0] fifo_count_unused;
    logic                      start_acc;
    logic                      beat_hs;
    logic                      last_beat;
    logic                      frame_done;

`ifdef ADC_AXIS_PACKER_TEST_PATTERN_EN
    logic [FW-1:0] pattern;

    always_comb begin
        pattern = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pattern[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(frame_cnt) + SAMPLE_W'(c);
        end
    end

    assign wr_frame = test_mode ? pattern : ch_data;
    assign wr_req   = test_mode || ch_valid;
`else
    assign wr_frame = ch_data;
    assign wr_req   = ch_valid;
`endif

    assign start_acc  = (state == IDLE) && sample_start && !start_q && (sample_len != 32'd0);
    assign beat_hs    = m_axis_tvalid && m_axis_tready;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign frame_done = beat_hs && last_beat;
    // The FIFO read register doubles as the holding register; refill it as its last beat leaves
    assign rd_en      = !fifo_empty && (!m_axis_tvalid || frame_done);
    assign wr_ok      = !fifo_full || rd_en;
    assign wr_en      = (state == CAPTURE) && wr_req && wr_ok;

    assign m_axis_tkeep = '1;
    assign m_axis_tlast = m_axis_tvalid && last_beat && (out_frame_cnt == len_q - 32'd1);

    always_comb begin
        m_axis_tdata = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == BW'(k)) begin
                m_axis_tdata = rd_frame[k*AXIS_W +: AXIS_W];
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (adc_clk),
        .rst_n   (adc_rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_frame),
        .rd_en   (rd_en),
        .rd_data (rd_frame),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_unused)
    );

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            len_q     <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            start_q <= sample_start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        len_q     <= sample_len;
                        frame_cnt <= '0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        frame_cnt <= frame_cnt + 32'd1;
                        if (frame_cnt + 32'd1 == len_q) begin
                            state <= DRAIN;
                        end
                    end else if (wr_req) begin
                        overflow <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (beat_hs && m_axis_tlast) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            m_axis_tvalid <= 1'b0;
            beat_cnt      <= '0;
            out_frame_cnt <= '0;
        end else begin
            if (start_acc) begin
                out_frame_cnt <= '0;
            end else if (frame_done) begin
                out_frame_cnt <= out_frame_cnt + 32'd1;
            end
            if (beat_hs) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (rd_en) begin
                m_axis_tvalid <= 1'b1;
            end else if (frame_done) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_axis_packer.sv
// tb/tb_adc_axis_packer.sv - directed self-checking bench for adc_axis_packer
module tb_adc_axis_packer;

    localparam int NUM_CH     = 4;
    localparam int SAMPLE_W   = 16;
    localparam int AXIS_W     = 32;
    localparam int FIFO_DEPTH = 64;
    localparam int FW         = NUM_CH * SAMPLE_W;
    localparam int BEATS      = FW / AXIS_W;

    logic                  adc_clk = 1'b0;
    logic                  adc_rst_n = 1'b0;
    logic [FW-1:0]         ch_data = '0;
    logic                  ch_valid = 1'b0;
    logic [31:0]           sample_len = '0;
    logic                  sample_start = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [AXIS_W-1:0]     m_axis_tdata;
    logic [AXIS_W/8-1:0]   m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b1;
`ifdef ADC_AXIS_PACKER_TEST_PATTERN_EN
    logic                  test_mode = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    bit free_mode = 1'b0;
    bit done_seen = 1'b0;
    int tlast_count = 0;
    int last_idx = -1;

    logic [AXIS_W-1:0] exp_q[$];
    bit                last_q[$];
    logic [AXIS_W-1:0] beat_log[$];

    always #5 adc_clk = ~adc_clk;

    adc_axis_packer #(
        .NUM_CH     (NUM_CH),
        .SAMPLE_W   (SAMPLE_W),
        .AXIS_W     (AXIS_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .adc_clk       (adc_clk),
        .adc_rst_n     (adc_rst_n),
        .ch_data       (ch_data),
        .ch_valid      (ch_valid),
        .sample_len    (sample_len),
        .sample_start  (sample_start),
`ifdef ADC_AXIS_PACKER_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk_frame(input int base, input int idx);
        logic [FW-1:0] f;
        for (int c = 0; c < NUM_CH; c++) begin
            f[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + idx * NUM_CH + c);
        end
        return f;
    endfunction

    task automatic push_frame(input logic [FW-1:0] f, input bit final_frame);
        for (int k = 0; k < BEATS; k++) begin
            exp_q.push_back(f[k*AXIS_W +: AXIS_W]);
            last_q.push_back(final_frame && (k == BEATS - 1));
        end
    endtask

    task automatic begin_test();
        beat_log.delete();
        tlast_count = 0;
        last_idx = -1;
        done_seen = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] len);
        sample_len = len;
        sample_start = 1'b1;
        tick();
        sample_start = 1'b0;
    endtask

    // The first len frames offered after an accepted start are the transfer; extras are ignored
    task automatic send_frames(input int base, input int len, input int extra, input int repulse);
        for (int i = 0; i < len + extra; i++) begin
            ch_data = mk_frame(base, i);
            ch_valid = 1'b1;
            sample_start = (i == repulse);
            if (i == repulse) sample_len = 32'd7;
            if (i < len) push_frame(ch_data, i == len - 1);
            tick();
        end
        ch_valid = 1'b0;
        sample_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done_seen && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", done_seen, 1);
    endtask

    always @(posedge adc_clk) begin
        #2;
        if (rdy_mode == 0) m_axis_tready = 1'b1;
        else if (rdy_mode == 1) m_axis_tready = ~m_axis_tready;
        else m_axis_tready = 1'b0;
    end

    logic              prev_stall = 1'b0;
    logic              prev_last_hs = 1'b0;
    logic [AXIS_W-1:0] prev_data = '0;
    logic              prev_tlast = 1'b0;

    always @(negedge adc_clk) begin
        if (!adc_rst_n) begin
            prev_stall = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            check("done_pulse", done, prev_last_hs);
            if (done) done_seen = 1'b1;
            if (prev_stall) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", m_axis_tlast, prev_tlast);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beat_log.push_back(m_axis_tdata);
                if (m_axis_tlast) begin
                    tlast_count++;
                    last_idx = beat_log.size() - 1;
                end
                check("tkeep", m_axis_tkeep, {(AXIS_W/8){1'b1}});
                check("busy_at_beat", busy, 1);
                if (!free_mode) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", m_axis_tdata, 0);
                    end else begin
                        check("tdata", m_axis_tdata, exp_q.pop_front());
                        check("tlast", m_axis_tlast, last_q.pop_front());
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_tlast = m_axis_tlast;
            prev_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int prev_f;
        logic [AXIS_W-1:0] b0;
        logic [AXIS_W-1:0] b1;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        adc_rst_n = 1'b1;
        tick(2);

        begin_test();
        start_xfer(32'd3);
        check("t1_busy_start", busy, 1);
        send_frames(16'h1000, 3, 2, -1);
        wait_done(200);
        check("t1_beats", beat_log.size(), 6);
        check("t1_tlast_count", tlast_count, 1);
        check("t1_tlast_idx", last_idx, 5);
        check("t1_first_beat", beat_log[0], 32'h1001_1000);
        check("t1_overflow", overflow, 0);
        check("t1_busy_end", busy, 0);
        check("t1_model_empty", exp_q.size(), 0);

        begin_test();
        rdy_mode = 1;
        start_xfer(32'd5);
        send_frames(16'h2000, 5, 0, -1);
        wait_done(300);
        rdy_mode = 0;
        tick(2);
        check("t2_beats", beat_log.size(), 10);
        check("t2_tlast_count", tlast_count, 1);
        check("t2_beat0", beat_log[0], 32'h2001_2000);
        check("t2_beat1", beat_log[1], 32'h2003_2002);
        check("t2_beat9", beat_log[9], 32'h2013_2012);

        begin_test();
        free_mode = 1'b1;
        rdy_mode = 2;
        tick(2);
        start_xfer(32'd200);
        for (int n = 0; n < 3000 && !done_seen; n++) begin
            ch_data = mk_frame(0, n);
            ch_valid = 1'b1;
            if (n == 10) check("t3_no_early_ovf", overflow, 0);
            if (n == 99) check("t3_overflow", overflow, 1);
            if (n == 100) rdy_mode = 0;
            tick();
        end
        ch_valid = 1'b0;
        check("done_seen", done_seen, 1);
        free_mode = 1'b0;
        check("t3_beats", beat_log.size(), 400);
        check("t3_tlast_count", tlast_count, 1);
        check("t3_tlast_idx", last_idx, 399);
        check("t3_overflow_sticky", overflow, 1);
        bad = 0;
        prev_f = -1;
        for (int j = 0; j < 200 && 2 * j + 1 < beat_log.size(); j++) begin
            b0 = beat_log[2*j];
            b1 = beat_log[2*j+1];
            if (b0[1:0] != 2'd0) bad++;
            if (b0[31:16] != b0[15:0] + 16'd1) bad++;
            if (b1[15:0] != b0[15:0] + 16'd2) bad++;
            if (b1[31:16] != b0[15:0] + 16'd3) bad++;
            if (int'(b0[15:0]) <= prev_f) bad++;
            prev_f = int'(b0[15:0]);
        end
        check("t3_order_errors", bad, 0);
        check("t3_first_beat", beat_log[0], 32'h0001_0000);

        begin_test();
        start_xfer(32'd0);
        tick(10);
        check("t4_zero_busy", busy, 0);
        check("t4_zero_beats", beat_log.size(), 0);
        begin_test();
        start_xfer(32'd3);
        send_frames(16'h4000, 3, 0, 1);
        wait_done(200);
        check("t4_repulse_beats", beat_log.size(), 6);
        check("t4_repulse_tlast", tlast_count, 1);
        tick(10);
        check("t4_no_restart", busy, 0);

        begin_test();
        start_xfer(32'd10);
        fork
            send_frames(16'h5000, 10, 0, -1);
            begin
                int n;
                n = 0;
                while (beat_log.size() < 3 && n < 100) begin
                    tick();
                    n++;
                end
                adc_rst_n = 1'b0;
                #1;
                check("t5_tvalid_abort", m_axis_tvalid, 0);
                check("t5_tlast_abort", m_axis_tlast, 0);
                check("t5_busy_abort", busy, 0);
            end
        join
        tick(2);
        adc_rst_n = 1'b1;
        exp_q.delete();
        last_q.delete();
        tick(5);
        check("t5_no_done", done_seen, 0);
        begin_test();
        start_xfer(32'd2);
        send_frames(16'h6000, 2, 0, -1);
        wait_done(200);
        check("t5_clean_beats", beat_log.size(), 4);
        check("t5_clean_tlast", tlast_count, 1);
        check("t5_clean_beat3", beat_log[3], 32'h6007_6006);

`ifdef ADC_AXIS_PACKER_TEST_PATTERN_EN
        begin_test();
        free_mode = 1'b1;
        test_mode = 1'b1;
        start_xfer(32'd2);
        wait_done(200);
        test_mode = 1'b0;
        free_mode = 1'b0;
        check("tp_beats", beat_log.size(), 4);
        check("tp_beat0", beat_log[0], 32'h0001_0000);
        check("tp_beat1", beat_log[1], 32'h0003_0002);
        check("tp_beat2", beat_log[2], 32'h0002_0001);
        check("tp_beat3", beat_log[3], 32'h0004_0003);
`endif

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_axis_packer.md
Name: adc_axis_packer

Overview:
- Parametrised single-clock successor to the 4-channel ADC capture-to-DMA block.
- Accepts NUM_CH parallel ADC samples per frame and captures exactly sample_len frames per start command.
- Buffers frames in an internal synchronous FIFO and serialises each frame into AXIS beats of AXIS_W bits for the AXI DMA S2MM port.
- Output is a fully AXIS-compliant master: tvalid is independent of tready, and tlast is asserted on the final beat of the transfer.

Parameters:
- NUM_CH, 4, number of ADC channels per frame (1..8).
- SAMPLE_W, 16, bits per channel sample.
- AXIS_W, 32, m_axis_tdata width. Must be a multiple of 8, and NUM_CH*SAMPLE_W must be a multiple of AXIS_W.
- FIFO_DEPTH, 64, frame-FIFO depth in frames. Power of two, at least 4.

Ports:
- adc_clk  in  1  sole clock; the ADC and AXIS sides share it.
- adc_rst_n  in  1  asynchronous, active-low reset.
- ch_data  in  NUM_CH*SAMPLE_W  channel samples; ch0 occupies bits [SAMPLE_W-1:0].
- ch_valid  in  1  the frame on ch_data is valid this cycle.
- sample_len  in  32  number of frames to capture; sampled at start.
- sample_start  in  1  start pulse or level; acts on its rising edge only.
- busy  out  1  high from accepted start until the last beat handshakes (the st_clr role).
- done  out  1  one-cycle pulse after the tlast handshake.
- overflow  out  1  sticky: at least one frame was dropped because the FIFO was full.
- m_axis_tdata  out  AXIS_W  beat data.
- m_axis_tkeep  out  AXIS_W/8  all ones.
- m_axis_tlast  out  1  final beat of the transfer.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset values:
  - Outputs: busy, done, overflow, tvalid and tlast are 0; tdata is 0.
  - Internal: FIFO empty, counters 0, state IDLE.
- Derived constants: BEATS = NUM_CH*SAMPLE_W/AXIS_W. Beat k carries frame bits [(k+1)*AXIS_W-1 : k*AXIS_W], so beat 0 holds ch0 first.
- State machine states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - Start is accepted on a rising edge of sample_start with sample_len != 0.
  - On accept: latch len_q = sample_len, clear frame_cnt and overflow, set busy, go to CAPTURE.
  - A rising edge with sample_len == 0 is ignored and busy stays 0.
- CAPTURE:
  - ch_valid with FIFO not full writes the frame and increments frame_cnt.
  - ch_valid with FIFO full drops the frame: frame_cnt is unchanged and overflow is set.
  - Because drops do not count, exactly len_q frames reach the stream.
  - When frame_cnt reaches len_q, go to DRAIN. Frames arriving after that are ignored and do not set overflow.
- DRAIN: wait for the tlast handshake, then clear busy, pulse done for one cycle, and return to IDLE.
- Start events while busy is high are ignored.
- Serialiser, FIFO read side:
  - Pops one frame into a holding register when the register is empty or its last beat is handshaking. This allows back-to-back beats across frames with no bubble.
  - tvalid stays high until tready is seen. tdata and tlast remain stable while tvalid && !tready.
  - beat_cnt wraps at BEATS-1. out_frame_cnt increments on the last beat of each frame.
  - tlast = tvalid && beat_cnt == BEATS-1 && out_frame_cnt == len_q-1.
- Latency: a write when the FIFO is empty and the holding register is idle gives tvalid 2 cycles later.
- Simultaneous FIFO write and read when full: the write is accepted, because full is evaluated before the read.
- Counters are 32 bits and compared for equality, so len_q = 2^32-1 is legal.
- An asynchronous reset mid-transfer aborts immediately: FIFO flushed, tvalid dropped, no tlast, no done.

Optional Feature:
- Macro: ADC_AXIS_PACKER_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode is 1, ch_data is replaced by a generated frame: channel c carries (frame_cnt[SAMPLE_W-1:0] + c).
  - The frame is written every cycle regardless of ch_valid, subject to FIFO full.
- When undefined: no port and no logic; ch_data is always used.

Decomposition:
- Package adc_axis_pkg:
  - state enum {IDLE, CAPTURE, DRAIN}.
  - Function calc_beats(NUM_CH, SAMPLE_W, AXIS_W).
  - Width function clog2-based FIFO pointer width.
  - Elaboration-time check that the frame width is divisible by AXIS_W.
- Sub-module sync_fifo (WIDTH, DEPTH), single clock:
  - Outputs full, empty and count.
  - First-word-fall-through is not required; the serialiser pipeline accounts for the read latency.

Test Plan:
- Defaults, sample_len=3, ch_valid every cycle, tready=1 -> exactly 6 beats, tlast on beat 6 only, done 1 cycle after it, overflow=0, busy high throughout the transfer.
- tready toggling 1-0-1-0 with sample_len=5 -> data held stable while stalled, 10 beats in order ch0|ch1 then ch2|ch3 per frame, one tlast.
- tready=0 for 100 cycles, FIFO_DEPTH=64, sample_len=200 -> overflow=1 after frame 64 is held. Once tready is restored, exactly 400 beats with tlast on beat 400.
- sample_len=0 start -> busy stays 0, no beats. sample_start re-pulsed mid-transfer -> ignored, beat count unchanged.
- adc_rst_n asserted after 3 beats of a 10-frame transfer -> tvalid=0 immediately, no done. A new start with sample_len=2 then produces a clean 4-beat packet.
- With the macro defined, test_mode=1 and sample_len=2 -> beats 0x00010000, 0x00030002, 0x00020001, 0x00040003.
